donut_motion_ctrl: RTL

DONUT_MOTION_CTRL -- requirements
Module: donut_motion_ctrl

---
 rtl/donut_pkg.sv | 24 ++
 rtl/bounce_axis.sv | 45 ++++
 rtl/donut_motion_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/donut_pkg.sv
// Shared definitions for the donut motion controller: FSM states,
// coordinate widths and default geometry.
package donut_pkg;

  localparam int COORD_W = 10;
  // One extra bit so step/clamp arithmetic can never wrap.
  localparam int CALC_W  = COORD_W + 1;

  localparam int DEF_X_MIN  = 160;
  localparam int DEF_X_MAX  = 480;
  localparam int DEF_Y_MIN  = 120;
  localparam int DEF_Y_MAX  = 360;
  localparam int DEF_STEP   = 2;
  localparam int DEF_HOME_X = 320;
  localparam int DEF_HOME_Y = 240;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_UPD_X  = 2'd1,
    ST_UPD_Y  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/bounce_axis.sv
// One axis of bounce motion: step the position in the current direction,
// clamp at the bounds and reverse direction when a bound is reached.
// Purely combinational.
module bounce_axis
  import donut_pkg::*;
#(
  parameter int MIN  = DEF_X_MIN,
  parameter int MAX  = DEF_X_MAX,
  parameter int STEP = DEF_STEP
) (
  input  logic [COORD_W-1:0] pos_i,
  input  logic               dir_i,   // 1 = increasing
  output logic [COORD_W-1:0] pos_o,
  output logic               dir_o
);

  logic [CALC_W-1:0] pos_w;
  logic [CALC_W-1:0] fwd_w;
  logic [CALC_W-1:0] res_w;

  // Step/clamp/reverse evaluated at CALC_W bits.
  always_comb begin
    pos_w = {1'b0, pos_i};
    fwd_w = pos_w + CALC_W'(STEP);
    res_w = pos_w;
    dir_o = dir_i;
    if (dir_i) begin
      if (fwd_w >= CALC_W'(MAX)) begin
        res_w = CALC_W'(MAX);
        dir_o = 1'b0;
      end else begin
        res_w = fwd_w;
      end
    end else begin
      if (pos_w <= CALC_W'(MIN + STEP)) begin
        res_w = CALC_W'(MIN);
        dir_o = 1'b1;
      end else begin
        res_w = pos_w - CALC_W'(STEP);
      end
    end
    pos_o = res_w[COORD_W-1:0];
  end

endmodule

// File: rtl/donut_motion_ctrl.sv
// Donut motion controller: once per accepted frame tick, moves a shadow
// centre position with bounce on X then Y, then commits it to cx/cy with a
// one-cycle cfg_valid pulse. cx/cy change only in COMMIT.
//
// Handshake: cfg_valid is a one-cycle, ready-less pulse; the consumer must
// take cx/cy in that cycle (they also stay constant until the next commit).
module donut_motion_ctrl
  import donut_pkg::*;
#(
  parameter int X_MIN  = DEF_X_MIN,
  parameter int X_MAX  = DEF_X_MAX,
  parameter int Y_MIN  = DEF_Y_MIN,
  parameter int Y_MAX  = DEF_Y_MAX,
  parameter int STEP   = DEF_STEP,
  parameter int HOME_X = DEF_HOME_X,
  parameter int HOME_Y = DEF_HOME_Y
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [1:0]         speed,
  input  logic               home,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               cfg_valid,
  output logic               overrun,
  output state_e             dbg_state
);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic                 dx_q, dx_d, dy_q, dy_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 move_q, move_d;
  logic                 homed_q, homed_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic [COORD_W-1:0]   bx_pos, by_pos;
  logic                 bx_dir, by_dir;
  logic [2:0]           speed_mask;

  bounce_axis #(.MIN(X_MIN), .MAX(X_MAX), .STEP(STEP)) u_bounce_x (
    .pos_i (sx_q),
    .dir_i (dx_q),
    .pos_o (bx_pos),
    .dir_o (bx_dir)
  );

  bounce_axis #(.MIN(Y_MIN), .MAX(Y_MAX), .STEP(STEP)) u_bounce_y (
    .pos_i (sy_q),
    .dir_i (dy_q),
    .pos_o (by_pos),
    .dir_o (by_dir)
  );

  // Low `speed` bits of the frame counter must be zero for a move.
  always_comb begin
    speed_mask = 3'(({1'b0, 3'b001} << speed) - 4'd1);
  end

  // State register and datapath registers; reset lands on HOME.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      sx_q      <= COORD_W'(HOME_X);
      sy_q      <= COORD_W'(HOME_Y);
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      cx_q      <= COORD_W'(HOME_X);
      cy_q      <= COORD_W'(HOME_Y);
      cnt_q     <= 3'd0;
      move_q    <= 1'b0;
      homed_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      homed_q   <= homed_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and datapath updates for WAIT -> UPD_X -> UPD_Y -> COMMIT.
  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    cnt_d     = cnt_q;
    move_d    = move_q;
    homed_d   = homed_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      ST_WAIT: begin
        if (frame_tick) begin
          state_d = ST_UPD_X;
          // Move decision uses the counter value before this tick's increment.
          move_d  = enable && ((cnt_q & speed_mask) == 3'd0);
          if (enable) cnt_d = cnt_q + 3'd1;
        end
      end
      ST_UPD_X: begin
        state_d = ST_UPD_Y;
        homed_d = home;
        if (home) begin
          sx_d  = COORD_W'(HOME_X);
          sy_d  = COORD_W'(HOME_Y);
          dx_d  = 1'b1;
          dy_d  = 1'b1;
          cnt_d = 3'd0;
        end else if (move_q) begin
          sx_d = bx_pos;
          dx_d = bx_dir;
        end
      end
      ST_UPD_Y: begin
        state_d = ST_COMMIT;
        // A home request taken in UPD_X suppresses the Y move.
        if (move_q && !homed_q) begin
          sy_d = by_pos;
          dy_d = by_dir;
        end
      end
      ST_COMMIT: begin
        state_d = ST_WAIT;
        cx_d    = sx_q;
        cy_d    = sy_q;
        valid_d = 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase

    // A tick that arrives mid-update is dropped and flagged.
    if (frame_tick && (state_q != ST_WAIT)) overrun_d = 1'b1;
  end

  assign cx        = cx_q;
  assign cy        = cy_q;
  assign cfg_valid = valid_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
